// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: fetch/data arbiter onto one single-port memory, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic              d_err_o,
    output logic [DATA_W-1:0] d_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_d_q;

    logic              grant_any;
    logic              pick_d;
    logic              d_misaligned;

    assign grant_any    = (state == IDLE) && (if_req_i || d_req_i);
    assign d_misaligned = ((d_size_i == SIZE_HALF) && d_addr_i[0]) ||
                          ((d_size_i == SIZE_WORD) && (d_addr_i[1:0] != 2'b00));

`ifdef MEM_ARB_RR_EN
    // Set when the data port won the most recent grant; a tie goes to the other requester.
    logic last_d_q;

    assign pick_d = d_req_i && (!if_req_i || !last_d_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (grant_any) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = d_req_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            wdata_q   <= '0;
            owner_d_q <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_any) begin
                owner_d_q <= pick_d;
                if (pick_d) begin
                    addr_q  <= d_addr_i;
                    we_q    <= d_we_i;
                    size_q  <= d_size_i;
                    wdata_q <= d_wdata_i;
                end else begin
                    // Fetches are always word reads.
                    addr_q  <= if_addr_i;
                    we_q    <= 1'b0;
                    size_q  <= SIZE_WORD;
                    wdata_q <= '0;
                end
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_size_o  = size_q;
    assign mem_wdata_o = wdata_q;

    always_comb begin
        state_next  = state;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        d_err_o     = 1'b0;
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        // Outputs are squashed while reset is held so nothing leaks before the reset edge.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if_gnt_o   = !pick_d;
                        d_gnt_o    = pick_d;
                        state_next = (pick_d && d_misaligned) ? ERR : REQ;
                    end
                end
                REQ: begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) begin
                        state_next = RSP;
                    end
                end
                RSP: begin
                    if (mem_rvalid_i) begin
                        if (owner_d_q) begin
                            d_rvalid_o = 1'b1;
                            d_rdata_o  = mem_rdata_i;
                        end else begin
                            if_rvalid_o = 1'b1;
                            if_rdata_o  = mem_rdata_i;
                        end
                        state_next = IDLE;
                    end
                end
                ERR: begin
                    d_rvalid_o = 1'b1;
                    d_err_o    = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_gnt_o, if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              d_req_i = 1'b0, d_we_i = 1'b0;
    logic [1:0]        d_size_i = 2'd0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [31:0]       d_wdata_i = '0;
    logic              d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0]       d_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [1:0]        mem_size_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;

    int vectors = 0;
    int miscompares = 0;
    bit last_d = 1'b0;   // model: data port won the most recent grant

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Arbitration rule: lone requester wins; ties go to data (fixed) or to whoever did not win last (round-robin).
    function automatic bit model_pick_d(input bit ireq, input bit dreq);
`ifdef MEM_ARB_RR_EN
        if (ireq && dreq) return !last_d;
`endif
        return dreq;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        if (sz == SZ_HALF) return a[0];
        if (sz == SZ_WORD) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Presents pending requests; a requester with nothing pending shows junk fields.
    task automatic drive_reqs(input bit pi, input bit pd, input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] dw, input logic [1:0] dsz, input bit dwe);
        if_req_i  = pi;
        if_addr_i = pi ? ia : $urandom;
        d_req_i   = pd;
        d_addr_i  = pd ? da : $urandom;
        d_wdata_i = pd ? dw : $urandom;
        d_size_i  = pd ? dsz : 2'($urandom_range(0, 2));
        d_we_i    = pd ? dwe : 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req_i = 1'b1; d_req_i = 1'b1; d_size_i = SZ_WORD; d_addr_i = 32'h40;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b, required 0 0", if_gnt_o, d_gnt_o);
            end
            vectors++;
            if ({mem_req_o, if_rvalid_o, d_rvalid_o, d_err_o} !== 4'b0 || if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_outputs: req/if_rv/d_rv/err=%b%b%b%b if_rdata=%h d_rdata=%h, required all 0",
                         mem_req_o, if_rvalid_o, d_rvalid_o, d_err_o, if_rdata_o, d_rdata_o);
            end
            vectors++;
            if (mem_addr_o !== '0 || mem_we_o !== 1'b0 || mem_size_o !== 2'b00 || mem_wdata_o !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_fields: addr=%h we=%b size=%b wdata=%h, required 0", mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        last_d = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk); if_req_i = 1'b1; if_addr_i = 32'h100; #1;
        vectors++;
        if ({if_gnt_o, d_gnt_o, mem_req_o} !== 3'b100) begin
            miscompares++; $display("FAIL fetch_gnt: if_gnt/d_gnt/mem_req=%b%b%b, required 100", if_gnt_o, d_gnt_o, mem_req_o);
        end
        last_d = 1'b0;
        @(negedge clk); if_req_i = 1'b0; if_addr_i = 32'h999; mem_gnt_i = 1'b1; #1;
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_size_o !== SZ_WORD || mem_wdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL fetch_mem: req=%b addr=%h we=%b size=%b wdata=%h, required 1 00000100 0 10 0",
                     mem_req_o, mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o);
        end
        @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; #1;
        vectors++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEAD_BEEF || d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_rsp: if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h mem_req=%b, required 1 deadbeef 0 0 0",
                     if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o, mem_req_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0; #1;
        vectors++;
        if (if_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            miscompares++; $display("FAIL fetch_pulse: if_rv=%b mem_req=%b, required 0 0", if_rvalid_o, mem_req_o);
        end
    endtask

    task automatic test_store_delayed();
        @(negedge clk); d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = SZ_WORD; d_addr_i = 32'h200; d_wdata_i = 32'h1234_5678; #1;
        vectors++;
        if ({if_gnt_o, d_gnt_o} !== 2'b01) begin
            miscompares++; $display("FAIL store_gnt: if_gnt/d_gnt=%b%b, required 01", if_gnt_o, d_gnt_o);
        end
        last_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); d_req_i = 1'b0; d_addr_i = $urandom; d_wdata_i = $urandom; d_we_i = 1'b0;
            mem_gnt_i = (i == 3); #1;
            vectors++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b1 || mem_size_o !== SZ_WORD || mem_wdata_o !== 32'h1234_5678) begin
                miscompares++;
                $display("FAIL store_hold cycle %0d: req=%b addr=%h we=%b size=%b wdata=%h, required 1 00000200 1 10 12345678",
                         i, mem_req_o, mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o);
            end
        end
        @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; #1;
        vectors++;
        if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b0 || if_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL store_rsp: d_rv=%b d_err=%b if_rv=%b mem_req=%b, required 1 0 0 0", d_rvalid_o, d_err_o, if_rvalid_o, mem_req_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz_tab [3] = '{SZ_HALF, SZ_WORD, SZ_WORD};
        logic [31:0] ad_tab [3] = '{32'h203, 32'h202, 32'h301};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = sz_tab[t]; d_addr_i = ad_tab[t]; #1;
            vectors++;
            if ({if_gnt_o, d_gnt_o} !== 2'b01) begin
                miscompares++; $display("FAIL misalign_gnt %0d: if_gnt/d_gnt=%b%b, required 01", t, if_gnt_o, d_gnt_o);
            end
            last_d = 1'b1;
            @(negedge clk); d_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; #1;
            vectors++;
            if ({mem_req_o, d_rvalid_o, d_err_o, if_rvalid_o} !== 4'b0110) begin
                miscompares++;
                $display("FAIL misalign_err %0d: mem_req/d_rv/d_err/if_rv=%b%b%b%b, required 0110", t, mem_req_o, d_rvalid_o, d_err_o, if_rvalid_o);
            end
            @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; #1;
            vectors++;
            if ({mem_req_o, d_rvalid_o, d_err_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL misalign_after %0d: mem_req/d_rv/d_err=%b%b%b, required 000", t, mem_req_o, d_rvalid_o, d_err_o);
            end
        end
    endtask

    task automatic test_contention();
`ifdef MEM_ARB_RR_EN
        bit exp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        bit exp_seq [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; last_d = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h400; d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_WORD; d_addr_i = 32'h800;
        for (int t = 0; t < 4; t++) begin
            #1;
            vectors++;
            if ({if_gnt_o, d_gnt_o} !== {!exp_seq[t], exp_seq[t]}) begin
                miscompares++;
                $display("FAIL contention_grant %0d: if_gnt/d_gnt=%b%b, required %b%b", t, if_gnt_o, d_gnt_o, !exp_seq[t], exp_seq[t]);
            end
            last_d = model_pick_d(1'b1, 1'b1);
            @(negedge clk); mem_gnt_i = 1'b1; #1;
            vectors++;
            if ({if_gnt_o, d_gnt_o} !== 2'b00 || mem_addr_o !== (exp_seq[t] ? 32'h800 : 32'h400)) begin
                miscompares++;
                $display("FAIL contention_busy %0d: gnts=%b%b addr=%h, required 00 %h", t, if_gnt_o, d_gnt_o, mem_addr_o,
                         exp_seq[t] ? 32'h800 : 32'h400);
            end
            @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom; #1;
            vectors++;
            if ({if_rvalid_o, d_rvalid_o} !== {!exp_seq[t], exp_seq[t]}) begin
                miscompares++;
                $display("FAIL contention_rsp %0d: if_rv/d_rv=%b%b, required %b%b", t, if_rvalid_o, d_rvalid_o, !exp_seq[t], exp_seq[t]);
            end
            @(negedge clk); mem_rvalid_i = 1'b0;
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); if_req_i = 1'b1; if_addr_i = 32'h500;
        @(negedge clk); if_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk); mem_gnt_i = 1'b0; rst_n = 1'b0; #1;
        vectors++;
        if ({if_rvalid_o, d_rvalid_o, mem_req_o} !== 3'b000) begin
            miscompares++; $display("FAIL resetmid_hold: if_rv/d_rv/mem_req=%b%b%b, required 000", if_rvalid_o, d_rvalid_o, mem_req_o);
        end
        @(negedge clk); rst_n = 1'b1; last_d = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; #1;
        vectors++;
        if ({if_rvalid_o, d_rvalid_o, mem_req_o} !== 3'b000 || if_rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL resetmid_late: if_rv/d_rv/mem_req=%b%b%b if_rdata=%h, required 000 0", if_rvalid_o, d_rvalid_o, mem_req_o, if_rdata_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0; d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_WORD; d_addr_i = 32'h600; #1;
        vectors++;
        if ({if_gnt_o, d_gnt_o} !== 2'b01) begin
            miscompares++; $display("FAIL resetmid_regrant: if_gnt/d_gnt=%b%b, required 01", if_gnt_o, d_gnt_o);
        end
        last_d = 1'b1;
        @(negedge clk); d_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0A0B_0C0D; #1;
        vectors++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h0A0B_0C0D) begin
            miscompares++; $display("FAIL resetmid_rsp: d_rv=%b d_rdata=%h, required 1 0a0b0c0d", d_rvalid_o, d_rdata_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0;
    endtask

    task automatic test_spurious();
        @(negedge clk); mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; #1;
        vectors++;
        if ({if_rvalid_o, d_rvalid_o, d_err_o, mem_req_o, if_gnt_o, d_gnt_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL spurious: if_rv/d_rv/err/mem_req/if_gnt/d_gnt=%b%b%b%b%b%b, required 000000",
                     if_rvalid_o, d_rvalid_o, d_err_o, mem_req_o, if_gnt_o, d_gnt_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h704; #1;
        vectors++;
        if ({if_gnt_o, d_gnt_o} !== 2'b10) begin
            miscompares++; $display("FAIL spurious_after: if_gnt/d_gnt=%b%b, required 10", if_gnt_o, d_gnt_o);
        end
        last_d = 1'b0;
        @(negedge clk); if_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222; #1;
        vectors++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h1111_2222) begin
            miscompares++; $display("FAIL spurious_rsp: if_rv=%b if_rdata=%h, required 1 11112222", if_rvalid_o, if_rdata_o);
        end
        @(negedge clk); mem_rvalid_i = 1'b0;
    endtask

    task automatic test_random(input int n);
        bit pi = 1'b0, pd = 1'b0, dwe = 1'b0, win_d, mis, ewe;
        logic [31:0] ia = '0, da = '0, dw = '0, ea, ewd, rd;
        logic [1:0]  dsz = SZ_WORD, esz;
        int gd, rdl;
        for (int k = 0; k < n; k++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin pi = 1'b1; ia = $urandom & ~32'h3; end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1'b1; da = $urandom; dw = $urandom; dsz = 2'($urandom_range(0, 2)); dwe = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) da = da & ~32'h3;
            end
            if (!pi && !pd) begin pi = 1'b1; ia = $urandom & ~32'h3; end

            @(negedge clk);
            drive_reqs(pi, pd, ia, da, dw, dsz, dwe);
            mem_gnt_i = 1'($urandom_range(0, 1)); mem_rvalid_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
            #1;
            win_d = model_pick_d(pi, pd);
            vectors++;
            if ({if_gnt_o, d_gnt_o} !== {!win_d, win_d} || {if_rvalid_o, d_rvalid_o, mem_req_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL rand_grant %0d: if_gnt/d_gnt=%b%b rv=%b%b mem_req=%b, required %b%b 00 0",
                         k, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, mem_req_o, !win_d, win_d);
            end
            last_d = win_d;
            if (win_d) begin ea = da; ewe = dwe; esz = dsz; ewd = dw; mis = model_misaligned(dsz, da); pd = 1'b0; end
            else begin ea = ia; ewe = 1'b0; esz = SZ_WORD; ewd = 32'h0; mis = 1'b0; pi = 1'b0; end

            if (mis) begin
                @(negedge clk);
                drive_reqs(pi, pd, ia, da, dw, dsz, dwe);
                mem_gnt_i = 1'($urandom_range(0, 1)); mem_rvalid_i = 1'($urandom_range(0, 1)); #1;
                vectors++;
                if ({mem_req_o, d_rvalid_o, d_err_o, if_rvalid_o, if_gnt_o, d_gnt_o} !== 6'b011000) begin
                    miscompares++;
                    $display("FAIL rand_err %0d: mem_req/d_rv/d_err/if_rv/if_gnt/d_gnt=%b%b%b%b%b%b, required 011000",
                             k, mem_req_o, d_rvalid_o, d_err_o, if_rvalid_o, if_gnt_o, d_gnt_o);
                end
            end else begin
                gd = $urandom_range(0, 3);
                for (int j = 0; j <= gd; j++) begin
                    @(negedge clk);
                    drive_reqs(pi, pd, ia, da, dw, dsz, dwe);
                    mem_gnt_i = (j == gd); mem_rvalid_i = 1'($urandom_range(0, 1)); #1;
                    vectors++;
                    if (mem_req_o !== 1'b1 || mem_addr_o !== ea || mem_we_o !== ewe || mem_size_o !== esz || mem_wdata_o !== ewd ||
                        {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o} !== 5'b0) begin
                        miscompares++;
                        $display("FAIL rand_req %0d.%0d: req=%b addr=%h we=%b size=%b wdata=%h gnt/rv/err=%b%b%b%b%b, required 1 %h %b %b %h 00000",
                                 k, j, mem_req_o, mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o,
                                 if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o, ea, ewe, esz, ewd);
                    end
                end
                rdl = $urandom_range(0, 2);
                for (int j = 0; j <= rdl; j++) begin
                    @(negedge clk);
                    drive_reqs(pi, pd, ia, da, dw, dsz, dwe);
                    rd = $urandom;
                    mem_gnt_i = 1'($urandom_range(0, 1)); mem_rvalid_i = (j == rdl); mem_rdata_i = rd; #1;
                    vectors++;
                    if (j < rdl) begin
                        if ({mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o} !== 6'b0) begin
                            miscompares++;
                            $display("FAIL rand_wait %0d.%0d: mem_req/gnts/rv/err=%b%b%b%b%b%b, required 000000",
                                     k, j, mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o);
                        end
                    end else if ({if_rvalid_o, d_rvalid_o} !== {!win_d, win_d} || d_err_o !== 1'b0 || mem_req_o !== 1'b0 ||
                                 (win_d ? if_rdata_o : d_rdata_o) !== 32'h0 ||
                                 (!ewe && (win_d ? d_rdata_o : if_rdata_o) !== rd)) begin
                        miscompares++;
                        $display("FAIL rand_rsp %0d: if_rv/d_rv=%b%b err=%b if_rdata=%h d_rdata=%h, required %b%b 0 owner data %h other 0",
                                 k, if_rvalid_o, d_rvalid_o, d_err_o, if_rdata_o, d_rdata_o, !win_d, win_d, rd);
                    end
                end
            end
        end
        @(negedge clk);
        if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_delayed();
        test_misaligned();
        test_contention();
        test_reset_mid();
        test_spurious();
        test_random(60);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of every address port.
REQ-002 SHALL have parameter DATA_W, fixed at 32, width of every data port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports if_req_i in 1, if_addr_i in ADDR_W, if_gnt_o out 1, if_rvalid_o out 1, if_rdata_o out 32: instruction fetch, word reads only.
REQ-006 SHALL have ports d_req_i in 1, d_we_i in 1, d_size_i in 2 (data_size_e), d_addr_i in ADDR_W, d_wdata_i in 32, d_gnt_o out 1, d_rvalid_o out 1, d_err_o out 1, d_rdata_o out 32: load/store port.
REQ-007 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_size_o out 2, mem_addr_o out ADDR_W, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32: shared single-port memory.

Function
REQ-008 SHALL use states IDLE, REQ, RSP, ERR; at most one transaction outstanding.
REQ-009 In IDLE with any request, SHALL pick one winner, assert its gnt_o combinationally that cycle, latch addr/we/size/wdata/owner, go to REQ.
REQ-010 SHALL never assert if_gnt_o and d_gnt_o in the same cycle; gnt_o only in IDLE.
REQ-011 Fetch requests SHALL be issued as non-write, size WORD, wdata 0.
REQ-012 In REQ, mem_req_o=1 with latched fields stable until mem_gnt_i=1, then go to RSP; mem_req_o first high the cycle after gnt_o.
REQ-013 In RSP, on mem_rvalid_i=1, SHALL assert owner's rvalid_o and drive its rdata_o = mem_rdata_i in that same cycle, then go to IDLE; stores also complete with rvalid_o (rdata don't-care).
REQ-014 mem_rvalid_i outside RSP SHALL be ignored; mem_gnt_i outside REQ SHALL be ignored.
REQ-015 Misaligned data request (HALF with addr[0]=1, WORD with addr[1:0]!=0) SHALL be granted, not forwarded to memory, go to ERR; next cycle d_rvalid_o=1, d_err_o=1, then IDLE.
REQ-016 d_err_o SHALL be 0 whenever d_rvalid_o is not asserted by ERR.
REQ-017 rdata_o of the non-owner SHALL be 0; rvalid_o SHALL be single-cycle pulses.
REQ-018 Minimum aligned transaction SHALL be 3 cycles gnt-to-IDLE (gnt, mem_req with mem_gnt, rvalid); new grant the cycle after rvalid.
REQ-019 Requesters SHALL hold req/fields until gnt; arbiter SHALL not require req held after gnt.

Reset
REQ-020 On rst_n=0 at a clock edge: state IDLE, latched fields 0, mem_req_o 0, all gnt/rvalid/err outputs 0, rdata outputs 0, round-robin pointer = fetch-last.
REQ-021 Reset mid-transaction SHALL abandon it: no rvalid_o issued; late mem_rvalid_i after reset ignored.
REQ-022 While rst_n=0, no gnt_o shall be asserted regardless of requests.

Configuration
REQ-023 Macro MEM_ARB_RR_EN: when defined, simultaneous requests granted round-robin (requester not granted last wins; pointer updates on each grant); when undefined, data port has fixed priority over fetch.
REQ-024 Single requests SHALL be granted immediately in both configurations; reset pointer makes data win the first tie either way.

Verification
REQ-025 Single fetch if_addr_i=0x100, mem_gnt_i immediate, rvalid with rdata 0xDEADBEEF one cycle later -> if_gnt_o cycle 0, mem_req_o/addr 0x100 cycle 1, if_rvalid_o with 0xDEADBEEF cycle 2.
REQ-026 Both requesting continuously for 4 transactions -> without MEM_ARB_RR_EN grants D,D,D,D; with it D,I,D,I.
REQ-027 Store d_addr_i=0x200, WORD, wdata 0x12345678, mem_gnt_i delayed 3 cycles -> mem_req_o held 4 cycles with stable fields, mem_we_o=1, d_rvalid_o on ack.
REQ-028 Load HALF at 0x203 -> d_gnt_o, no mem_req_o, next cycle d_rvalid_o=1 and d_err_o=1.
REQ-029 rst_n=0 during RSP then mem_rvalid_i=1 after reset release -> no if_rvalid_o/d_rvalid_o, state IDLE, next request granted normally.
REQ-030 Spurious mem_rvalid_i=1 in IDLE -> no rvalid_o asserted, state unchanged.
